// File: rtl/alu_ctrl_mc.sv
// ALU control decode plus an iterative shift-add multiplier sequencer with a PC stall handshake.
// Optional macro MUL_EARLY_EXIT_EN: finish a mul as soon as the remaining multiplier bits are zero.
module alu_ctrl_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [5:0]       funct_i,
  input  logic [2:0]       ALUOp_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic [3:0]       ALUCtrl_o,
  output logic             shamt_select,
  output logic             mux_jump_select,
  output logic             illegal_o,
  output logic             stall_o,
  output logic             mul_done_o,
  output logic [WIDTH-1:0] mul_result_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d, result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         dec_ctrl;
  logic               dec_shamt, dec_jump, dec_ill, start;

  always_comb begin
    dec_ctrl  = 4'b1111;
    dec_shamt = 1'b0;
    dec_jump  = 1'b0;
    dec_ill   = 1'b0;
    case (ALUOp_i)
      3'd0: begin
        case (funct_i)
          6'd3:  begin dec_ctrl = 4'b1000; dec_shamt = 1'b1; end
          6'd7:  dec_ctrl = 4'b1001;
          6'd24: dec_ctrl = 4'b0101;
          6'd32: dec_ctrl = 4'b0010;
          6'd34: dec_ctrl = 4'b0110;
          6'd36: dec_ctrl = 4'b0000;
          6'd37: dec_ctrl = 4'b0001;
          6'd42: dec_ctrl = 4'b0100;
          6'd8:  begin dec_ctrl = 4'b0010; dec_jump = 1'b1; end
          default: dec_ill = 1'b1;
        endcase
      end
      3'd1: dec_ctrl = 4'b0111;
      3'd2: dec_ctrl = 4'b1010;
      3'd3: dec_ctrl = 4'b0010;
      3'd4: dec_ctrl = 4'b0011;
      3'd5: dec_ctrl = 4'b0001;
      3'd6: dec_ctrl = 4'b1011;
      default: dec_ctrl = 4'b1111;
    endcase
  end

  assign start = (state_q == IDLE) && valid_i && (ALUOp_i == 3'd0) && (funct_i == 6'd24);

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    stall_o    = 1'b0;
    mul_done_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = src1_i;
          mplier_d = src2_i;
          acc_d    = '0;
          cnt_d    = '0;
          stall_o  = 1'b1;
          state_d  = BUSY;
`ifdef MUL_EARLY_EXIT_EN
          if (src2_i == '0) begin
            state_d  = DONE;
            result_d = '0;
          end
`endif
        end
      end
      BUSY: begin
        stall_o  = 1'b1;
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // Result is captured on the exit edge so it is already valid during DONE.
`ifdef MUL_EARLY_EXIT_EN
        if (cnt_q == LAST || mplier_d == '0) begin
`else
        if (cnt_q == LAST) begin
`endif
          state_d  = DONE;
          result_d = acc_d;
        end
      end
      DONE: begin
        mul_done_o = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (state_q == IDLE) begin
      ALUCtrl_o       = dec_ctrl;
      shamt_select    = dec_shamt;
      mux_jump_select = dec_jump;
      illegal_o       = dec_ill;
    end else begin
      ALUCtrl_o       = 4'b0101;
      shamt_select    = 1'b0;
      mux_jump_select = 1'b0;
      illegal_o       = 1'b0;
    end
  end

  assign mul_result_o = result_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: doc/alu_ctrl_mc.md
Name: alu_ctrl_mc

Overview:
Multi-cycle successor to the single-cycle ALU controller. It keeps the funct/ALUOp decode, now parametrised in datapath width. It adds an iterative shift-add multiplier sequencer for funct 24 (mul), with a stall handshake toward the PC/pipeline control. It sits between the main Decoder and the ALU/result mux in the CPU datapath.

Parameters:
WIDTH, 32, operand and product width in bits (product truncated to WIDTH).
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk_i  in  1  system clock, rising edge.
rst_i  in  1  reset, asynchronous, active-low.
valid_i  in  1  instruction in decode is valid this cycle.
funct_i  in  6  R-type funct field.
ALUOp_i  in  3  ALU operation class from Decoder.
src1_i  in  WIDTH  rs operand (multiplicand).
src2_i  in  WIDTH  rt operand (multiplier).
ALUCtrl_o  out  4  ALU control code.
shamt_select  out  1  select shamt as ALU source A.
mux_jump_select  out  1  select register jump target (jr).
illegal_o  out  1  undecodable funct with ALUOp 0.
stall_o  out  1  freeze PC/IF; mul in progress.
mul_done_o  out  1  one-cycle pulse; mul_result_o valid.
mul_result_o  out  WIDTH  product low WIDTH bits.

Behaviour:
- Decode is combinational from funct_i/ALUOp_i; FSM affects only the outputs listed below.
- ALUOp 0, funct: 3 -> 1000; 7 -> 1001; 24 -> 0101; 32 -> 0010; 34 -> 0110; 36 -> 0000; 37 -> 0001; 42 -> 0100; 8 -> 0010.
- ALUOp 0, any other funct: ALUCtrl_o = 1111, illegal_o = 1.
- ALUOp 1..6 -> 0111, 1010, 0010, 0011, 0001, 1011; ALUOp 7 -> 1111 with illegal_o = 0.
- shamt_select = 1 only for ALUOp 0 / funct 3. mux_jump_select = 1 only for ALUOp 0 / funct 8. Both 0 otherwise. No latches: every output is assigned on every path.
- FSM states: IDLE, BUSY, DONE.
- IDLE: if valid_i and ALUOp_i==0 and funct_i==24, start a mul in cycle T:
  - latch mcand = src1_i, mplier = src2_i, acc = 0, cnt = 0;
  - go to BUSY;
  - stall_o asserts combinationally in cycle T.
- BUSY, each cycle:
  - if mplier[0], acc += mcand (mod 2^WIDTH);
  - mcand <<= 1; mplier >>= 1; cnt++;
  - when cnt reaches WIDTH-1 on that edge, go to DONE.
  - Exactly WIDTH BUSY cycles: T+1 .. T+WIDTH.
- DONE (cycle T+WIDTH+1): mul_result_o = acc; mul_done_o = 1; stall_o = 0; next state IDLE.
- A new mul can start in the cycle after DONE.
- stall_o = 1 in cycle T and all BUSY cycles; 0 in DONE and in IDLE without a start.
- While BUSY/DONE, ALUCtrl_o is forced to 0101 and shamt_select, mux_jump_select, illegal_o are forced to 0. valid_i and the decode inputs are ignored.
- mul_result_o holds its value until the next DONE. Arithmetic is unsigned; the low WIDTH bits equal the two's-complement signed product.
- Reset (any time, including mid-BUSY): immediately IDLE. acc, mcand, mplier, cnt and mul_result_o are cleared to 0; stall_o = 0; mul_done_o = 0. A partial product is discarded and never reported.

Optional Feature:
MUL_EARLY_EXIT_EN
- Defined: in BUSY, if the shifted mplier becomes 0 on an edge, go to DONE on that edge regardless of cnt. A multiplier of 0 at start goes IDLE -> DONE directly, skipping BUSY. Latency becomes (index of highest set bit of src2 + 1) BUSY cycles.
- Undefined: fixed WIDTH BUSY cycles for every mul.

Test Plan:
- WIDTH=32, each ALUOp 1..6 and every listed funct under ALUOp 0 -> ALUCtrl_o matches the table; funct 3 -> shamt_select = 1; funct 8 -> mux_jump_select = 1; funct 9 -> 1111 with illegal_o = 1.
- mul 7*6 started at cycle T -> stall_o high T..T+32; mul_done_o pulses at T+33 with mul_result_o = 42; stall_o = 0 at T+33.
- mul 0xFFFFFFFF*2 -> mul_result_o = 0xFFFFFFFE; then 0x80000000*0x80000000 -> 0x00000000. Both are back-to-back starts, the second in the cycle after the first DONE.
- Assert rst_i low at BUSY cycle 10 of 5*5 -> same-instant IDLE, stall_o = 0, mul_result_o = 0, no mul_done_o pulse. A following 3*3 returns 9.
- During BUSY, drive valid_i with funct 34 -> ignored; ALUCtrl_o stays 0101, no restart, result unaffected.
- With MUL_EARLY_EXIT_EN: 3*1 -> mul_done_o at T+2, result 3. 9*0 -> mul_done_o at T+1, result 0. Without the macro, 3*1 completes at T+33.
